// File: rtl/red_pitaya_bus_sequencer.sv
// red_pitaya_bus_sequencer: ramps a target register through a sequence of values, verifying each write by read-back
// Ports:
//   clk_i, rstn_i                     clock, synchronous active-low reset
//   start_i, abort_i                  run request (honoured in IDLE), run termination
//   target_addr_i, start_val_i,       run configuration, latched when a run is accepted
//   step_i, nsteps_i, period_i
//   m_addr_o, m_wen_o, m_ren_o,       bus master: address, write/read strobes, write data,
//   m_wdata_o, m_ack_i, m_rdata_i     acknowledge and read data from the responder
//   busy_o, done_o, err_o, cur_val_o  status: running, completion pulse, sticky error, last written value
module red_pitaya_bus_sequencer #(
   parameter int GAINBITS = 24,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [15:0]         target_addr_i,
   input  logic [GAINBITS-1:0] start_val_i,
   input  logic [GAINBITS-1:0] step_i,
   input  logic [15:0]         nsteps_i,
   input  logic [15:0]         period_i,
   output logic [15:0]         m_addr_o,
   output logic                m_wen_o,
   output logic                m_ren_o,
   output logic [31:0]         m_wdata_o,
   input  logic                m_ack_i,
   input  logic [31:0]         m_rdata_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [GAINBITS-1:0] cur_val_o
);
   typedef enum logic [2:0] {IDLE, WR, WR_WAIT, RD, RD_WAIT, HOLD} state_t;
   state_t r_state, w_next;
   logic [15:0] r_addr, r_period, r_cnt;
   logic [GAINBITS-1:0] r_val, r_step, r_cur, w_sat;
   logic [31:0] r_tmr;
   logic r_done, r_err;
   logic [GAINBITS:0] w_sum;
   logic w_accept, w_done, w_err, w_tmo, w_hold_end, w_match, w_unused;
   // one extra bit exposes signed overflow; saturate towards the sign of the true sum
   assign w_sum      = {r_val[GAINBITS-1], r_val} + {r_step[GAINBITS-1], r_step};
   assign w_sat      = (w_sum[GAINBITS] ^ w_sum[GAINBITS-1]) ?
                       {w_sum[GAINBITS], {(GAINBITS-1){~w_sum[GAINBITS]}}} : w_sum[GAINBITS-1:0];
   // wait states start counting at 0, so the last accepted ack cycle is count TIMEOUT-1
   assign w_tmo      = r_tmr == 32'(TIMEOUT - 1);
   // HOLD starts counting at 1, so period 0 and 1 both give a single hold cycle
   assign w_hold_end = r_tmr >= {16'd0, r_period};
   assign w_match    = m_rdata_i[GAINBITS-1:0] == r_val;
   assign w_unused   = &{1'b0, m_rdata_i[31:GAINBITS]};
   assign m_addr_o   = r_addr;
   assign m_wdata_o  = {{(32-GAINBITS){r_val[GAINBITS-1]}}, r_val};
   assign m_wen_o    = r_state == WR;
   assign m_ren_o    = r_state == RD;
   assign busy_o     = r_state != IDLE;
   assign done_o     = r_done;
   assign err_o      = r_err;
   assign cur_val_o  = r_cur;
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_done   = 1'b0;
      w_err    = 1'b0;
      if (abort_i)
         w_next = IDLE;
      else
         case (r_state)
            IDLE: if (start_i) begin
               w_accept = 1'b1;
               w_done   = nsteps_i == 16'd0;
               w_next   = (nsteps_i == 16'd0) ? IDLE : WR;
            end
            WR: w_next = WR_WAIT;
            WR_WAIT: begin
               w_err  = !m_ack_i && w_tmo;
               w_next = m_ack_i ? RD : (w_tmo ? IDLE : WR_WAIT);
            end
            RD: w_next = RD_WAIT;
            RD_WAIT: if (m_ack_i) begin
               w_err  = !w_match;
               w_done = w_match && r_cnt == 16'd1;
               w_next = (!w_match || r_cnt == 16'd1) ? IDLE : HOLD;
            end else begin
               w_err  = w_tmo;
               w_next = w_tmo ? IDLE : RD_WAIT;
            end
            HOLD: w_next = w_hold_end ? WR : HOLD;
            default: w_next = IDLE;
         endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_period <= '0;
         r_cnt    <= '0;
         r_val    <= '0;
         r_step   <= '0;
         r_cur    <= '0;
         r_tmr    <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_done;
         r_tmr   <= (w_next != r_state) ? ((w_next == HOLD) ? 32'd1 : 32'd0) : r_tmr + 32'd1;
         if (w_accept) begin
            r_addr   <= target_addr_i;
            r_period <= period_i;
            r_cnt    <= nsteps_i;
            r_val    <= start_val_i;
            r_step   <= step_i;
            r_err    <= 1'b0;
         end
         if (w_err)
            r_err <= 1'b1;
         if (r_state == WR)
            r_cur <= r_val;
         if (r_state == RD_WAIT && w_next == HOLD)
            r_cnt <= r_cnt - 16'd1;
         if (r_state == HOLD && w_next == WR)
            r_val <= w_sat;
      end
   end
endmodule

// File: tb/tb_red_pitaya_bus_sequencer.sv
// tb_red_pitaya_bus_sequencer: scoreboard bench driving ramp runs against an echoing/faulty bus responder
module tb_red_pitaya_bus_sequencer;
   localparam int GB   = 24;
   localparam int TO   = 20;
   localparam int VMAX = (1 << (GB - 1)) - 1;
   localparam int VMIN = -(1 << (GB - 1));
   typedef struct {
      int          kind;
      logic [15:0] addr;
      logic [31:0] data;
      int          dt;
   } ev_t;
   logic clk = 0, rstn = 0, start = 0, abort = 0, ack = 0;
   logic [15:0] taddr = 0, nsteps = 0, period = 0;
   logic [GB-1:0] sval = 0, step = 0;
   logic [31:0] rdata = 0;
   logic [15:0] m_addr;
   logic wen, ren, busy, done, err;
   logic [31:0] wdata;
   logic [GB-1:0] cur;
   ev_t sb[$];
   int checks = 0, errors = 0, cyc = 0, last_w = 0, nstb = 0, resp_mode = 0, resp_dly = 0;
   logic prev_err = 0;
   red_pitaya_bus_sequencer #(.GAINBITS(GB), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
      .target_addr_i(taddr), .start_val_i(sval), .step_i(step), .nsteps_i(nsteps), .period_i(period),
      .m_addr_o(m_addr), .m_wen_o(wen), .m_ren_o(ren), .m_wdata_o(wdata),
      .m_ack_i(ack), .m_rdata_i(rdata),
      .busy_o(busy), .done_o(done), .err_o(err), .cur_val_o(cur)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #900000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end
   function automatic void chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endfunction
   function automatic void push(int k, logic [15:0] a, logic [31:0] dv, int dt);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = dv;
      e.dt   = dt;
      sb.push_back(e);
   endfunction
   function automatic int sat(int x);
      return (x > VMAX) ? VMAX : (x < VMIN) ? VMIN : x;
   endfunction
   // kinds: 0 write, 1 read, 2 done, 3 error; dt = cycles since last write strobe (-1: unchecked)
   function automatic void expect_ev(int k, logic [15:0] a, logic [31:0] dv, string nm);
      ev_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_unexpected act=event exp=none", nm);
         return;
      end
      e = sb.pop_front();
      chk({nm, "_kind"}, k, e.kind);
      if (k < 2) chk({nm, "_addr"}, a, e.addr);
      if (k == 0) chk({nm, "_data"}, dv, e.data);
      if (e.dt >= 0) chk({nm, "_timing"}, cyc - last_w, e.dt);
   endfunction
   // responder: acks resp_dly cycles after the first wait cycle, echoing the last written word
   initial begin
      bit pend;
      int cd;
      logic [31:0] last;
      pend = 0;
      cd   = 0;
      last = 0;
      forever begin
         @(negedge clk);
         ack = 0;
         if (pend) begin
            if (cd == 0) begin
               ack   = resp_mode != 1;
               rdata = (resp_mode == 2) ? last ^ 32'd1 : last;
               pend  = 0;
            end else cd--;
         end
         if (wen || ren) begin
            pend = 1;
            cd   = resp_dly;
            if (wen) last = wdata;
         end
      end
   end
   always @(negedge clk) begin
      if (rstn) begin
         if (wen && ren) begin
            checks++;
            errors++;
            $display("FAIL strobe_excl act=both exp=one");
         end
         if (wen) begin
            nstb++;
            expect_ev(0, m_addr, wdata, "write");
            last_w = cyc;
         end
         if (ren) begin
            nstb++;
            expect_ev(1, m_addr, 32'd0, "read");
         end
         if (done) expect_ev(2, 16'd0, 32'd0, "done");
         if (err && !prev_err) expect_ev(3, 16'd0, 32'd0, "err");
      end
      prev_err = err;
   end
   // modes: 0 echo, 1 never ack, 2 corrupt read-back, 3 aborted in first RD_WAIT, 4 reset in first WR_WAIT
   function automatic void model(logic [15:0] a, int sv, int st, int n, int p, int m, int d);
      int v, gap;
      v   = sv;
      gap = 4 + 2 * d + ((p < 1) ? 1 : p);
      if (n == 0) push(2, 16'd0, 32'd0, -1);
      else if (m == 1 || d >= TO) begin
         push(0, a, v, -1);
         push(3, 16'd0, 32'd0, TO + 1);
      end else if (m == 4) push(0, a, v, -1);
      else if (m == 3) begin
         push(0, a, v, -1);
         push(1, a, 32'd0, -1);
      end else if (m == 2) begin
         push(0, a, v, -1);
         push(1, a, 32'd0, -1);
         push(3, 16'd0, 32'd0, 4 + 2 * d);
      end else begin
         for (int i = 0; i < n; i++) begin
            push(0, a, v, (i == 0) ? -1 : gap);
            push(1, a, 32'd0, -1);
            v = sat(v + st);
         end
         push(2, 16'd0, 32'd0, 4 + 2 * d);
      end
   endfunction
   task automatic kick(input logic [15:0] a, input int sv, input int st, input int n, input int p,
                       input int m, input int d);
      resp_mode = m;
      resp_dly  = d;
      model(a, sv, st, n, p, m, d);
      taddr  = a;
      sval   = sv[GB-1:0];
      step   = st[GB-1:0];
      nsteps = n[15:0];
      period = p[15:0];
      start  = 1;
      @(negedge clk);
      start  = 0;
      taddr  = 16'($urandom);
      sval   = GB'($urandom);
      step   = GB'($urandom);
      nsteps = 16'($urandom);
      period = 16'($urandom);
      chk("err_clear", err, 0);
   endtask
   task automatic finish_run();
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         ok = sb.size() == 0 && !busy;
         if (!ok) @(negedge clk);
      end
      chk("run_complete", ok, 1);
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      chk("idle_busy", busy, 0);
      sb.delete();
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, m_addr, 0);
      chk({tag, "_wen"}, wen, 0);
      chk({tag, "_ren"}, ren, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_cur"}, cur, 0);
   endtask
   initial begin
      bit seen;
      int s;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rstn = 1;
      @(negedge clk);
      kick(16'h108, 100, 50, 3, 4, 0, 1);
      finish_run();
      chk("cur_ramp", cur, 200);
      kick(16'h10C, 'h7FFFF0, 'h20, 2, 1, 0, 0);
      finish_run();
      chk("cur_sat_pos", cur, 24'h7FFFFF);
      kick(16'h110, VMIN + 5, -100, 3, 0, 0, 2);
      finish_run();
      chk("cur_sat_neg", cur, 24'h800000);
      kick(16'h120, 7, 1, 0, 3, 0, 0);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      finish_run();
      kick(16'h124, 1234, 1, 1, 1, 0, TO - 1);
      finish_run();
      kick(16'h128, 1234, 1, 1, 1, 0, TO);
      finish_run();
      kick(16'h12C, 55, 1, 2, 2, 1, 0);
      finish_run();
      kick(16'h130, 77, 3, 3, 2, 2, 0);
      finish_run();
      kick(16'h134, 500, 10, 3, 2, 3, 1);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         seen = ren;
         if (!seen) @(negedge clk);
      end
      chk("abort_ren_seen", seen, 1);
      repeat (2) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abort_idle", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      finish_run();
      kick(16'h138, 900, 5, 3, 2, 4, 5);
      @(negedge clk);
      rstn = 0;
      @(negedge clk);
      chk_zero("rst_mid");
      s    = nstb;
      rstn = 1;
      repeat (12) @(negedge clk);
      chk("rst_no_strobe", nstb, s);
      chk_zero("rst_after");
      finish_run();
      for (int r = 0; r < 25; r++) begin
         int sv, st, n, p, d, m;
         sv = int'($urandom_range(0, (1 << GB) - 1)) + VMIN;
         st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (1 << GB) - 1)) + VMIN
                                          : int'($urandom_range(0, 200)) - 100;
         n  = int'($urandom_range(0, 5));
         p  = int'($urandom_range(0, 6));
         d  = int'($urandom_range(0, 3));
         m  = ($urandom_range(0, 7) == 0) ? 2 : 0;
         kick(16'($urandom), sv, st, n, p, m, d);
         finish_run();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
